// File: rtl/sdram_usb_streamer.sv
// rtl/sdram_usb_streamer.sv - drains SDRAM read-back FIFO samples into ping-pong EP1 IN packet banks
module sdram_usb_streamer #(
    parameter int PKT_BYTES = 64,
    parameter int TIMEOUT   = 4800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_rd_data,
    output logic        fifo_rd,
    output logic [3:0]  ram_we,
    output logic [4:0]  ram_addr,
    output logic [31:0] ram_wdata,
    output logic        pkt_valid,
    output logic        pkt_bank,
    output logic [6:0]  pkt_len,
    input  logic        pkt_ack,
    input  logic        bank_release,
    input  logic        bank_rel_id
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {FILL, SETTLE, COMMIT, WAIT_BANK} state_t;

    state_t          state;
    logic            cur_bank;
    logic [1:0]      bank_busy;
    logic [6:0]      byte_cnt;
    logic [TW-1:0]   tcnt;

    logic            has_data;
    logic            tout_hit;
    logic            early_commit;
    logic            can_pop;
    logic            full_next;
    logic            next_bank_free;

    // A flush/timeout commit suppresses the pop in its own cycle so the packet length is final.
    always_comb begin
        has_data       = (byte_cnt != 7'd0);
        tout_hit       = has_data && (tcnt >= TW'(TIMEOUT - 1));
        early_commit   = has_data && (flush || tout_hit);
        can_pop        = !rst && (state == FILL) && enable && !fifo_empty &&
                         (byte_cnt < 7'(PKT_BYTES)) && !bank_busy[cur_bank] && !early_commit;
        fifo_rd        = can_pop;
        full_next      = ((byte_cnt + (can_pop ? 7'd2 : 7'd0)) == 7'(PKT_BYTES));
        next_bank_free = !bank_busy[~cur_bank] || (bank_release && (bank_rel_id == ~cur_bank));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cur_bank  <= 1'b0;
            bank_busy <= 2'b00;
            byte_cnt  <= 7'd0;
            tcnt      <= '0;
            ram_we    <= 4'b0000;
            ram_addr  <= 5'd0;
            ram_wdata <= 32'd0;
            pkt_valid <= 1'b0;
            pkt_bank  <= 1'b0;
            pkt_len   <= 7'd0;
        end else begin
            ram_we <= 4'b0000;
            if (can_pop) begin
                ram_we    <= byte_cnt[1] ? 4'b1100 : 4'b0011;
                ram_addr  <= {cur_bank, byte_cnt[5:2]};
                ram_wdata <= {fifo_rd_data, fifo_rd_data};
                byte_cnt  <= byte_cnt + 7'd2;
            end

            // tcnt reads k in the k-th cycle after the first pop of a packet.
            if (state == FILL) begin
                if (can_pop && !has_data)
                    tcnt <= TW'(1);
                else if (has_data)
                    tcnt <= tcnt + TW'(1);
            end

            if (bank_release)
                bank_busy[bank_rel_id] <= 1'b0;

            case (state)
                FILL: begin
                    if (full_next || early_commit)
                        state <= SETTLE;
                end
                SETTLE: begin
                    pkt_valid <= 1'b1;
                    pkt_bank  <= cur_bank;
                    pkt_len   <= byte_cnt;
                    state     <= COMMIT;
                end
                COMMIT: begin
                    if (pkt_ack) begin
                        pkt_valid           <= 1'b0;
                        bank_busy[cur_bank] <= 1'b1;
                        cur_bank            <= ~cur_bank;
                        byte_cnt            <= 7'd0;
                        tcnt                <= '0;
                        state               <= next_bank_free ? FILL : WAIT_BANK;
                    end
                end
                WAIT_BANK: begin
                    if (bank_release && (bank_rel_id == cur_bank))
                        state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_usb_streamer.sv
// tb/tb_sdram_usb_streamer.sv - bench for sdram_usb_streamer against a packet-level reference model
module tb_sdram_usb_streamer;

    localparam int PKT_BYTES = 64;
    localparam int TIMEOUT   = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        fifo_empty;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd;
    logic [3:0]  ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        pkt_valid;
    logic        pkt_bank;
    logic [6:0]  pkt_len;
    logic        pkt_ack;
    logic        bank_release;
    logic        bank_rel_id;

    always #5 clk = ~clk;

    sdram_usb_streamer #(.PKT_BYTES(PKT_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd      (fifo_rd),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .pkt_valid    (pkt_valid),
        .pkt_bank     (pkt_bank),
        .pkt_len      (pkt_len),
        .pkt_ack      (pkt_ack),
        .bank_release (bank_release),
        .bank_rel_id  (bank_rel_id)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // FIFO model and host-side reference state
    logic [15:0] fifo_q[$];
    logic [15:0] cur_pkt[$];
    logic [40:0] exp_wr[$];
    logic        stall    = 1'b0;
    int          stall_pct = 0;
    logic        pop_flag = 1'b0;
    logic [1:0]  m_busy   = 2'b00;
    logic        m_cur    = 1'b0;
    logic        pv_prev  = 1'b0;
    logic [15:0] next_val = 16'd0;
    logic [15:0] m_d;
    logic [3:0]  m_we;
    int          m_idx;
    int cyc = 0, n_pops = 0, n_pkts = 0;
    int first_pop_cyc = 0, last_pop_cyc = 0, valid_cyc = 0;

    function automatic void refresh();
        fifo_empty   = stall || (fifo_q.size() == 0);
        fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 16'd0;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (pop_flag) begin
            fifo_q.delete(0);
            pop_flag = 1'b0;
        end
        stall = ($urandom_range(99) < stall_pct);
        refresh();
    end

    always @(negedge clk) begin
        if (rst) begin
            cur_pkt.delete();
            exp_wr.delete();
            m_busy  = 2'b00;
            m_cur   = 1'b0;
            pv_prev = 1'b0;
        end else begin
            if (ram_we != 4'b0000) begin
                if (exp_wr.size() == 0) check("wr_unexpected", ram_we, 4'b0000);
                else check("wr", {ram_addr, ram_we, ram_wdata}, exp_wr.pop_front());
            end
            if (fifo_rd) begin
                check("pop_allowed", {pkt_valid, m_busy[m_cur]}, 2'b00);
                m_d   = fifo_q[0];
                m_idx = cur_pkt.size();
                if (m_idx == 0) first_pop_cyc = cyc;
                m_we = (m_idx % 2 == 1) ? 4'b1100 : 4'b0011;
                exp_wr.push_back({m_cur, 4'(m_idx / 2), m_we, m_d, m_d});
                cur_pkt.push_back(m_d);
                last_pop_cyc = cyc;
                n_pops++;
                pop_flag = 1'b1;
            end
            if (pkt_valid && !pv_prev) begin
                check("pkt_len", pkt_len, 2 * cur_pkt.size());
                check("pkt_bank", pkt_bank, m_cur);
                valid_cyc = cyc;
                n_pkts++;
                cur_pkt.delete();
            end
            if (bank_release) m_busy[bank_rel_id] = 1'b0;
            if (pkt_valid && pkt_ack) begin
                m_busy[m_cur] = 1'b1;
                m_cur = ~m_cur;
            end
            pv_prev = pkt_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n);
        repeat (n) begin
            fifo_q.push_back(next_val);
            next_val++;
        end
        refresh();
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int k = 0;
        while (!pkt_valid && k < limit) begin
            tick();
            k++;
        end
        if (!pkt_valid) check(tag, pkt_valid, 1);
        tick();
    endtask

    task automatic do_ack();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
    endtask

    task automatic release_bank(input logic b);
        bank_release = 1'b1;
        bank_rel_id  = b;
        tick();
        bank_release = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    logic       stable;
    logic       hold_bank;
    logic [6:0] hold_len;
    int         pops_before;
    int         k;

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; pkt_ack = 1'b0;
        bank_release = 1'b0; bank_rel_id = 1'b0;
        refresh();
        repeat (3) tick();
        check("reset_outs", {fifo_rd, ram_we, ram_addr, ram_wdata, pkt_valid, pkt_bank, pkt_len}, 64'd0);

        // full packet into bank 0 at one sample per cycle
        rst = 1'b0; enable = 1'b1;
        push_n(32);
        wait_valid("t1_timeout", 100);
        check("t1_pops", n_pops, 32);
        check("t1_burst", last_pop_cyc - first_pop_cyc, 31);
        check("t1_latency", valid_cyc - last_pop_cyc, 2);
        do_ack();

        // bank 1 fills, then both banks busy
        push_n(32);
        wait_valid("t2_timeout", 100);
        check("t2_bank", pkt_bank, 1);
        check("t2_len", pkt_len, 64);
        do_ack();
        push_n(3);
        repeat (4) tick();
        check("t2_wait_fifo_rd", fifo_rd, 0);
        check("t2_wait_pops", n_pops, 64);
        release_bank(1'b0);

        // partial packet committed by timeout
        wait_valid("t3_timeout", TIMEOUT + 20);
        check("t3_len", pkt_len, 6);
        check("t3_bank", pkt_bank, 0);
        check("t3_latency", valid_cyc - first_pop_cyc, TIMEOUT + 1);
        do_ack();
        release_bank(1'b1);

        // flush commit, then flush with nothing buffered
        push_n(5);
        repeat (8) tick();
        pulse_flush();
        wait_valid("t4_timeout", 10);
        check("t4_len", pkt_len, 10);
        check("t4_bank", pkt_bank, 1);
        check("t4_early", (valid_cyc - first_pop_cyc) < TIMEOUT, 1);
        do_ack();
        release_bank(1'b0);
        pulse_flush();
        repeat (5) tick();
        check("t4_empty_flush", pkt_valid, 0);

        // ack withheld, then ack and release of the other bank together
        push_n(10);
        repeat (14) tick();
        pulse_flush();
        wait_valid("t5_timeout", 10);
        hold_bank = pkt_bank;
        hold_len  = pkt_len;
        check("t5_len", hold_len, 20);
        push_n(10);
        pops_before = n_pops;
        stable = 1'b1;
        repeat (50) begin
            tick();
            if (pkt_valid !== 1'b1 || pkt_bank !== hold_bank || pkt_len !== hold_len || fifo_rd !== 1'b0)
                stable = 1'b0;
        end
        check("t5_stable", stable, 1);
        check("t5_no_pops", n_pops, pops_before);
        pkt_ack = 1'b1; bank_release = 1'b1; bank_rel_id = 1'b1;
        tick();
        pkt_ack = 1'b0; bank_release = 1'b0;
        check("t5_resume", fifo_rd, 1);

        // reset in the middle of a packet
        k = 0;
        while (cur_pkt.size() < 10 && k < 30) begin
            tick();
            k++;
        end
        check("t6_fill", cur_pkt.size(), 10);
        tick();
        rst = 1'b1;
        tick();
        check("t6_reset_outs", {fifo_rd, ram_we, ram_addr, ram_wdata, pkt_valid, pkt_bank, pkt_len}, 64'd0);
        rst = 1'b0;
        push_n(4);
        k = 0;
        while (ram_we == 4'b0000 && k < 10) begin
            tick();
            k++;
        end
        check("t6_first_addr", ram_addr, 0);
        check("t6_first_we", ram_we, 4'b0011);
        repeat (6) tick();
        pulse_flush();
        wait_valid("t6_timeout", 10);
        check("t6_len", pkt_len, 8);
        do_ack();

        // randomized traffic
        stall_pct = 25;
        repeat (4000) begin
            if ($urandom_range(99) < 30 && fifo_q.size() < 200) push_n(1);
            enable       = ($urandom_range(99) < 90);
            flush        = ($urandom_range(99) < 2);
            pkt_ack      = pkt_valid && ($urandom_range(99) < 30);
            bank_release = ($urandom_range(99) < 8);
            bank_rel_id  = 1'($urandom_range(1));
            tick();
        end

        // drain everything that is left
        flush = 1'b0; enable = 1'b1; stall_pct = 0;
        repeat (600) begin
            pkt_ack      = pkt_valid;
            bank_release = 1'b1;
            bank_rel_id  = cyc[0];
            tick();
        end
        pkt_ack = 1'b0; bank_release = 1'b0;
        tick();
        check("drain_fifo", fifo_q.size(), 0);
        check("drain_writes", exp_wr.size(), 0);
        check("drain_partial", cur_pkt.size(), 0);
        check("drain_valid", pkt_valid, 0);
        check("pkts_seen", n_pkts > 20, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
